// File: rtl/pipe_pair_adder_pkg.sv
// Shared types and the pair-add helper for the streaming pair adder.
// Optional build macro: PIPE_PAIR_ADDER_SATURATE_EN (saturating sum on carry-out).
package pipe_pair_adder_pkg;

   localparam int unsigned DATA_W = 16;

   typedef enum logic {
      S_WAIT_A = 1'b0,
      S_WAIT_B = 1'b1
   } pair_state_e;

   typedef struct packed {
      logic              carry;
      logic [DATA_W-1:0] sum;
   } pair_sum_t;

   // A+B with carry-out; on saturating builds a carry forces the sum to all ones
   function automatic pair_sum_t add_pair(input logic [DATA_W-1:0] a,
                                          input logic [DATA_W-1:0] b);
      pair_sum_t       r;
      logic [DATA_W:0] full_sum;
      full_sum = {1'b0, a} + {1'b0, b};
      r.carry  = full_sum[DATA_W];
`ifdef PIPE_PAIR_ADDER_SATURATE_EN
      r.sum    = full_sum[DATA_W] ? {DATA_W{1'b1}} : full_sum[DATA_W-1:0];
`else
      r.sum    = full_sum[DATA_W-1:0];
`endif
      return r;
   endfunction

endpackage

// File: rtl/pipe_pair_adder_sync_fifo_rd1.sv
// Single-clock result FIFO with registered read data and an occupancy count.
// An empty pop returns zero; a push while full is accepted only with a same-cycle pop.
module pipe_pair_adder_sync_fifo_rd1
   import pipe_pair_adder_pkg::*;
#(
   parameter int unsigned FIFO_AW = 10
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic [FIFO_AW:0]  count,
   output logic              full_c,
   output logic              empty_c
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned CNT_W = FIFO_AW + 1;

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic               push_ok;
   logic               pop_ok;

   assign full_c  = (count == CNT_W'(DEPTH));
   assign empty_c = (count == '0);
   assign push_ok = push & (~full_c | pop);
   assign pop_ok  = pop & ~empty_c;

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Pointers, occupancy and registered read port
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         pop_data <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + FIFO_AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (pop_ok)   pop_data <= mem[rd_ptr];
         else if (pop) pop_data <= '0;
      end
   end

endmodule

// File: rtl/pipe_pair_adder.sv
// Streaming pair adder: pairs consecutive PipeIn words (A then B), buffers A+B in a
// FIFO drained by PipeOut, and exports status for WireOuts.
// Optional build macro: PIPE_PAIR_ADDER_SATURATE_EN (saturating sum on carry-out).
module pipe_pair_adder
   import pipe_pair_adder_pkg::*;
#(
   parameter int unsigned FIFO_AW     = 10,
   parameter int unsigned BLOCK_WORDS = 256
)
(
   input  logic              ti_clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              pipe_in_write,
   input  logic [DATA_W-1:0] pipe_in_data,
   output logic              pipe_in_ready,
   input  logic              pipe_out_read,
   output logic [DATA_W-1:0] pipe_out_data,
   output logic              pipe_out_ready,
   output logic [FIFO_AW:0]  result_count,
   output logic              pending,
   output logic              overflow,
   output logic              underflow,
   output logic [15:0]       carry_count
);

   localparam int unsigned DEPTH = 1 << FIFO_AW;
   localparam int unsigned CNT_W = FIFO_AW + 1;
   localparam int unsigned HALF  = BLOCK_WORDS / 2;

   pair_state_e       state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic              sum_vld_q, sum_vld_d;
   logic              carry_inc_c;
   pair_sum_t         add_res_c;
   logic              srst_c;
   logic              full_c;
   logic              empty_c;
   logic [CNT_W:0]    used_c;

   assign srst_c  = reset | clear;
   assign pending = (state_q == S_WAIT_B);

   // Pairing FSM: next state, held A word and sum pipeline load
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      sum_d       = sum_q;
      sum_vld_d   = 1'b0;
      carry_inc_c = 1'b0;
      add_res_c   = add_pair(a_q, pipe_in_data);
      case (state_q)
         S_WAIT_A: begin
            if (pipe_in_write) begin
               a_d     = pipe_in_data;
               state_d = S_WAIT_B;
            end
         end
         S_WAIT_B: begin
            if (pipe_in_write) begin
               sum_d       = add_res_c.sum;
               sum_vld_d   = 1'b1;
               carry_inc_c = add_res_c.carry;
               state_d     = S_WAIT_A;
            end
         end
      endcase
   end

   // FSM state, held A word, sum pipeline register and carry counter
   always_ff @(posedge ti_clk) begin
      if (srst_c) begin
         state_q     <= S_WAIT_A;
         a_q         <= '0;
         sum_q       <= '0;
         sum_vld_q   <= 1'b0;
         carry_count <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         sum_q       <= sum_d;
         sum_vld_q   <= sum_vld_d;
         carry_count <= carry_count + 16'(carry_inc_c);
      end
   end

   pipe_pair_adder_sync_fifo_rd1 #(
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk       (ti_clk),
      .reset     (srst_c),
      .push      (sum_vld_q),
      .push_data (sum_q),
      .pop       (pipe_out_read),
      .pop_data  (pipe_out_data),
      .count     (result_count),
      .full_c    (full_c),
      .empty_c   (empty_c)
   );

   // Occupancy including the result still in flight in the sum register
   assign used_c = (CNT_W+1)'(result_count) + (CNT_W+1)'(sum_vld_q);

   // Sticky error flags and registered block-ready indications
   always_ff @(posedge ti_clk) begin
      if (srst_c) begin
         overflow       <= 1'b0;
         underflow      <= 1'b0;
         pipe_in_ready  <= 1'b1;
         pipe_out_ready <= 1'b0;
      end else begin
         overflow       <= overflow | (sum_vld_q & full_c & ~pipe_out_read);
         underflow      <= underflow | (pipe_out_read & empty_c);
         pipe_in_ready  <= (used_c <= (CNT_W+1)'(DEPTH - HALF));
         pipe_out_ready <= (result_count >= CNT_W'(HALF));
      end
   end

endmodule

// File: tb/tb_pipe_pair_adder.sv
// Directed self-checking bench for pipe_pair_adder (default FIFO_AW/BLOCK_WORDS).
module tb_pipe_pair_adder;

   localparam int unsigned FIFO_AW     = 10;
   localparam int unsigned DEPTH       = 1 << FIFO_AW;
   localparam int unsigned BLOCK_WORDS = 256;

   logic              ti_clk = 1'b0;
   logic              reset;
   logic              clear;
   logic              pipe_in_write;
   logic [15:0]       pipe_in_data;
   logic              pipe_in_ready;
   logic              pipe_out_read;
   logic [15:0]       pipe_out_data;
   logic              pipe_out_ready;
   logic [FIFO_AW:0]  result_count;
   logic              pending;
   logic              overflow;
   logic              underflow;
   logic [15:0]       carry_count;

   always #5 ti_clk = ~ti_clk;

   pipe_pair_adder #(
      .FIFO_AW     (FIFO_AW),
      .BLOCK_WORDS (BLOCK_WORDS)
   ) dut (
      .ti_clk         (ti_clk),
      .reset          (reset),
      .clear          (clear),
      .pipe_in_write  (pipe_in_write),
      .pipe_in_data   (pipe_in_data),
      .pipe_in_ready  (pipe_in_ready),
      .pipe_out_read  (pipe_out_read),
      .pipe_out_data  (pipe_out_data),
      .pipe_out_ready (pipe_out_ready),
      .result_count   (result_count),
      .pending        (pending),
      .overflow       (overflow),
      .underflow      (underflow),
      .carry_count    (carry_count)
   );

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] sum_wrap;
      logic [15:0] sum_sat;
      logic        c;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ti_clk);
      #1;
   endtask

   task automatic write_word(input logic [15:0] d);
      pipe_in_write = 1'b1;
      pipe_in_data  = d;
      tick();
      pipe_in_write = 1'b0;
   endtask

   task automatic read_word(output logic [15:0] d);
      pipe_out_read = 1'b1;
      tick();
      pipe_out_read = 1'b0;
      d = pipe_out_data;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   function automatic logic [16:0] model_add(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] t;
      t = {1'b0, a} + {1'b0, b};
`ifdef PIPE_PAIR_ADDER_SATURATE_EN
      if (t[16]) t[15:0] = 16'hFFFF;
`endif
      return t;
   endfunction

   initial begin
      logic [15:0] d;
      logic [15:0] exp_carry;
      logic [15:0] exp_sum;
      logic [15:0] words [BLOCK_WORDS];
      logic [16:0] m;

      vecs[0] = '{16'h1234, 16'h1111, 16'h2345, 16'h2345, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0002, 16'h0001, 16'hFFFF, 1'b1};
      vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
      vecs[3] = '{16'h8000, 16'h8000, 16'h0000, 16'hFFFF, 1'b1};
      vecs[4] = '{16'h7FFF, 16'h0001, 16'h8000, 16'h8000, 1'b0};
      vecs[5] = '{16'hABCD, 16'h5433, 16'h0000, 16'hFFFF, 1'b1};
      vecs[6] = '{16'h00FF, 16'hFF00, 16'hFFFF, 16'hFFFF, 1'b0};
      vecs[7] = '{16'h1357, 16'h2468, 16'h37BF, 16'h37BF, 1'b0};

      reset = 1'b1; clear = 1'b0;
      pipe_in_write = 1'b0; pipe_in_data = '0; pipe_out_read = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_in_ready",  32'(pipe_in_ready),  32'd1);
      check("rst_out_ready", 32'(pipe_out_ready), 32'd0);
      check("rst_count",     32'(result_count),   32'd0);
      check("rst_pending",   32'(pending),        32'd0);
      check("rst_overflow",  32'(overflow),       32'd0);
      check("rst_underflow", 32'(underflow),      32'd0);
      check("rst_carry",     32'(carry_count),    32'd0);
      check("rst_data",      32'(pipe_out_data),  32'd0);

      // Table-driven pairs: pairing, latency, sum and carry counting
      exp_carry = '0;
      for (int i = 0; i < 8; i++) begin
         write_word(vecs[i].a);
         check("pend_after_a", 32'(pending), 32'd1);
         write_word(vecs[i].b);
         check("pend_after_b", 32'(pending), 32'd0);
         check("count_before_push", 32'(result_count), 32'd0);
         tick();
         check("count_after_push", 32'(result_count), 32'd1);
         exp_carry = exp_carry + 16'(vecs[i].c);
         check("carry_count", 32'(carry_count), 32'(exp_carry));
         read_word(d);
`ifdef PIPE_PAIR_ADDER_SATURATE_EN
         check("vec_sum", 32'(d), 32'(vecs[i].sum_sat));
`else
         check("vec_sum", 32'(d), 32'(vecs[i].sum_wrap));
`endif
      end

      // Odd word stays pending, then soft clear discards it
      write_word(16'h0001);
      write_word(16'h0002);
      write_word(16'h0003);
      tick();
      check("odd_pending", 32'(pending), 32'd1);
      read_word(d);
      check("odd_sum", 32'(d), 32'h0003);
      pulse_clear();
      check("clr_pending", 32'(pending), 32'd0);
      check("clr_count", 32'(result_count), 32'd0);
      check("clr_carry", 32'(carry_count), 32'd0);
      write_word(16'h0004);
      write_word(16'h0005);
      tick();
      read_word(d);
      check("post_clr_sum", 32'(d), 32'h0009);

      // Fill the FIFO completely
      pulse_clear();
      for (int i = 0; i < int'(DEPTH); i++) begin
         write_word(16'(i));
         write_word(16'h0000);
      end
      tick();
      tick();
      check("full_count", 32'(result_count), 32'(DEPTH));
      check("full_overflow", 32'(overflow), 32'd0);
      check("full_in_ready", 32'(pipe_in_ready), 32'd0);
      check("full_out_ready", 32'(pipe_out_ready), 32'd1);

      // Push and pop in the same cycle while full
      write_word(16'h0100);
      write_word(16'h0001);
      pipe_out_read = 1'b1;
      tick();
      pipe_out_read = 1'b0;
      check("pp_data", 32'(pipe_out_data), 32'h0000);
      check("pp_count", 32'(result_count), 32'(DEPTH));
      check("pp_overflow", 32'(overflow), 32'd0);

      // Push while full with no pop: dropped, but its carry still counts
      write_word(16'hFFFF);
      write_word(16'h0002);
      tick();
      tick();
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_count", 32'(result_count), 32'(DEPTH));
      check("ovf_carry", 32'(carry_count), 32'd1);

      // Drain in order, then one read on empty
      for (int i = 1; i < int'(DEPTH); i++) begin
         read_word(d);
         check("drain_data", 32'(d), 32'(i));
      end
      read_word(d);
      check("drain_last", 32'(d), 32'h0101);
      check("drain_underflow_pre", 32'(underflow), 32'd0);
      read_word(d);
      check("empty_read_data", 32'(d), 32'h0000);
      check("empty_underflow", 32'(underflow), 32'd1);
      check("empty_count", 32'(result_count), 32'd0);
      tick();
      check("empty_in_ready", 32'(pipe_in_ready), 32'd1);

      // Block transfer of BLOCK_WORDS words against a software model
      pulse_clear();
      for (int k = 0; k < int'(BLOCK_WORDS); k++) words[k] = 16'(k * 16'h0123 + 16'h8000);
      check("blk_out_ready_pre", 32'(pipe_out_ready), 32'd0);
      for (int k = 0; k < int'(BLOCK_WORDS); k++) write_word(words[k]);
      tick();
      check("blk_count", 32'(result_count), 32'(BLOCK_WORDS / 2));
      check("blk_out_ready_lag", 32'(pipe_out_ready), 32'd0);
      tick();
      check("blk_out_ready", 32'(pipe_out_ready), 32'd1);
      exp_carry = '0;
      for (int j = 0; j < int'(BLOCK_WORDS / 2); j++) begin
         m = model_add(words[2*j], words[2*j+1]);
         exp_carry = exp_carry + 16'(m[16]);
         exp_sum = m[15:0];
         read_word(d);
         check("blk_data", 32'(d), 32'(exp_sum));
      end
      check("blk_carry", 32'(carry_count), 32'(exp_carry));
      tick();
      check("blk_out_ready_post", 32'(pipe_out_ready), 32'd0);

      // Reset in the middle of a block with strobes active
      read_word(d);
      write_word(16'h0011);
      write_word(16'h0022);
      tick();
      read_word(d);
      check("pre_rst_data", 32'(d), 32'h0033);
      for (int k = 1; k <= 5; k++) write_word(16'(k));
      reset = 1'b1;
      pipe_in_write = 1'b1;
      pipe_in_data  = 16'h0007;
      pipe_out_read = 1'b1;
      tick();
      reset = 1'b0; pipe_in_write = 1'b0; pipe_out_read = 1'b0;
      check("mid_rst_in_ready",  32'(pipe_in_ready),  32'd1);
      check("mid_rst_out_ready", 32'(pipe_out_ready), 32'd0);
      check("mid_rst_count",     32'(result_count),   32'd0);
      check("mid_rst_pending",   32'(pending),        32'd0);
      check("mid_rst_overflow",  32'(overflow),       32'd0);
      check("mid_rst_underflow", 32'(underflow),      32'd0);
      check("mid_rst_carry",     32'(carry_count),    32'd0);
      check("mid_rst_data",      32'(pipe_out_data),  32'd0);
      tick();
      tick();
      check("mid_rst_count_settled", 32'(result_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
